// File: rtl/fetch_pkg.sv
// Shared types for the fetch sequencer: FSM states,
// default widths and the prefetch queue entry layout.
package fetch_pkg;

    localparam int FETCH_ADDR_W  = 4;
    localparam int FETCH_INSTR_W = 16;
    localparam int FETCH_DEPTH   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  addr;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of fetched {addr, instr} pairs.
// Ports: push_i/entry_i write, pop_i read, flush_i
// empties, head_o is the oldest entry, count_o its fill.
import fetch_pkg::*;

module fetch_queue #(
    parameter int DEPTH = FETCH_DEPTH,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  fetch_entry_t entry_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t    mem_q [DEPTH];
    logic [PW-1:0]   rd_q;
    logic [PW-1:0]   wr_q;
    logic [CW-1:0]   cnt_q;

    function automatic logic [PW-1:0] inc(
        input logic [PW-1:0] p
    );
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= entry_i;
                wr_q        <= inc(wr_q);
            end
            if (pop_i) begin
                rd_q <= inc(rd_q);
            end
            unique case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives the PC register's next value,
// issues one imem read per PC, queues results for decode.
// Ports: pc_i/next_o PC loop, imem_* memory read,
// instr_* decode handshake, redirect_* branch/jump.
import fetch_pkg::*;

module fetch_sequencer #(
    parameter int ADDR_W  = FETCH_ADDR_W,
    parameter int INSTR_W = FETCH_INSTR_W,
    parameter int DEPTH   = FETCH_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic [ADDR_W-1:0]  next_o,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  instr_pc_o,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_addr_i
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [CW-1:0]     count;
    fetch_entry_t      head;
    fetch_entry_t      entry;
    logic              push;
    logic              pop;
    logic              valid;
    logic              space_now;
    logic              space_after;

    assign valid     = (count != '0);
    assign pop       = valid & instr_ready_i;
    assign space_now = (count < CW'(DEPTH));
    // After a push, room remains if decode also pops
    // or the queue held fewer than DEPTH-1 entries.
    assign space_after = pop | (count < CW'(DEPTH - 1));

    assign entry.addr  = addr_q;
    assign entry.instr = imem_rdata_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!redirect_i && space_now) begin
                    state_d = WAIT;
                    addr_d  = pc_i;
                end
            end
            WAIT: begin
                if (imem_ack_i) begin
                    if (redirect_i) begin
                        state_d = IDLE;
                    end else begin
                        push = 1'b1;
                        if (space_after) begin
                            addr_d = pc_i + ADDR_W'(1);
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else if (redirect_i) begin
                    // Response still owed by memory.
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        next_o = pc_i;
        if (!rst_n) begin
            next_o = '0;
        end else if (redirect_i) begin
            next_o = redirect_addr_i;
        end else if (state_q == WAIT && imem_ack_i) begin
            next_o = pc_i + ADDR_W'(1);
        end
    end

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .entry_i (entry),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .head_o  (head),
        .count_o (count)
    );

    assign imem_req_o    = (state_q != IDLE);
    assign imem_addr_o   = addr_q;
    assign instr_valid_o = valid;
    assign instr_o       = valid ? head.instr : '0;
    assign instr_pc_o    = valid ? head.addr : '0;

endmodule
